step_source_arbiter: RTL and testbench

Step/direction arbiter and pulse sequencer in front of the microstepper. It shares the single step/dir input between two requesters: the internal DDA motion timer and the external STEP/DIR pins. It grants one step at a time and enforces direction setup time, minimum pulse width and minimum low time. It also maintains a signed position counter for the SPI register file.

---
 rtl/step_source_arbiter_if.sv | 41 ++++
 rtl/step_source_arbiter.sv | 145 ++++++++++++++
 tb/tb_step_source_arbiter.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/step_source_arbiter_if.sv
// Step/direction request bus between the two requesters and the arbiter.
// The slave side is the arbiter; the master side drives the requests.
interface step_source_arbiter_if #(
   parameter int POS_W = 32
);
   logic [1:0]       src_sel;
   logic             halt;
   logic             int_valid;
   logic             int_dir;
   logic             int_ready;
   logic             ext_valid;
   logic             ext_dir;
   logic             ext_ready;
   logic             pos_load;
   logic [POS_W-1:0] pos_load_val;
   logic             step_out;
   logic             dir_out;
   logic             busy;
   logic             grant_src;
   logic [POS_W-1:0] position;

   modport slave (
      input  src_sel, halt,
      input  int_valid, int_dir,
      input  ext_valid, ext_dir,
      input  pos_load, pos_load_val,
      output int_ready, ext_ready,
      output step_out, dir_out, busy,
      output grant_src, position
   );

   modport master (
      output src_sel, halt,
      output int_valid, int_dir,
      output ext_valid, ext_dir,
      output pos_load, pos_load_val,
      input  int_ready, ext_ready,
      input  step_out, dir_out, busy,
      input  grant_src, position
   );
endinterface

// File: rtl/step_source_arbiter.sv
// Step/dir arbiter: grants one step at a time from the DDA or the pins,
// sequences dir setup, pulse width and low time, and tracks position.
module step_source_arbiter #(
   parameter int PULSE_W   = 8,
   parameter int DIR_SETUP = 4,
   parameter int DIR_HOLD  = 4,
   parameter int POS_W     = 32
) (
   input logic                   clk,
   input logic                   reset,
   step_source_arbiter_if.slave  bus
);
   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_PULSE,
      S_HOLD
   } state_t;

   localparam logic [7:0] LP_SETUP = 8'(DIR_SETUP - 1);
   localparam logic [7:0] LP_PULSE = 8'(PULSE_W - 1);
   localparam logic [7:0] LP_HOLD  = 8'(DIR_HOLD - 1);

   state_t           r_state;
   state_t           w_state_nx;
   logic [7:0]       r_cnt;
   logic [7:0]       w_cnt_nx;
   logic             r_dir;
   logic             r_gsrc;
   logic             r_rr;
   logic [POS_W-1:0] r_pos;

   logic w_open;
   logic w_int_req;
   logic w_ext_req;
   logic w_int_win;
   logic w_ext_win;
   logic w_grant;
   logic w_grant_src;
   logic w_req_dir;
   logic w_enter_pulse;

   // Arbitration: r_rr=1 means external has priority on a tie.
   always_comb begin
      w_open      = (r_state == S_IDLE) && !bus.halt;
      w_int_req   = bus.src_sel[0] && bus.int_valid;
      w_ext_req   = bus.src_sel[1] && bus.ext_valid;
      w_int_win   = w_open && w_int_req && (!w_ext_req || !r_rr);
      w_ext_win   = w_open && w_ext_req && (!w_int_req || r_rr);
      w_grant     = w_int_win || w_ext_win;
      w_grant_src = w_ext_win;
      w_req_dir   = w_ext_win ? bus.ext_dir : bus.int_dir;
   end

   // Next state and phase counter for the pulse sequencer.
   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      unique case (r_state)
         S_IDLE: begin
            if (w_grant) begin
               if (w_req_dir != r_dir) begin
                  w_state_nx = S_SETUP;
                  w_cnt_nx   = LP_SETUP;
               end else begin
                  w_state_nx = S_PULSE;
                  w_cnt_nx   = LP_PULSE;
               end
            end
         end
         S_SETUP: begin
            if (r_cnt == 8'd0) begin
               w_state_nx = S_PULSE;
               w_cnt_nx   = LP_PULSE;
            end else begin
               w_cnt_nx = r_cnt - 8'd1;
            end
         end
         S_PULSE: begin
            if (r_cnt == 8'd0) begin
               w_state_nx = S_HOLD;
               w_cnt_nx   = LP_HOLD;
            end else begin
               w_cnt_nx = r_cnt - 8'd1;
            end
         end
         S_HOLD: begin
            if (r_cnt == 8'd0) begin
               w_state_nx = S_IDLE;
               w_cnt_nx   = 8'd0;
            end else begin
               w_cnt_nx = r_cnt - 8'd1;
            end
         end
         default: begin
            w_state_nx = S_IDLE;
            w_cnt_nx   = 8'd0;
         end
      endcase
      w_enter_pulse = (w_state_nx == S_PULSE) && (r_state != S_PULSE);
   end

   // Sequencer state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= 8'd0;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
      end
   end

   // Latch direction, grant source and tie-break pointer on each grant.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_dir  <= 1'b0;
         r_gsrc <= 1'b0;
         r_rr   <= 1'b0;
      end else if (w_grant) begin
         r_dir  <= w_req_dir;
         r_gsrc <= w_grant_src;
         r_rr   <= ~w_grant_src;
      end
   end

   // Position counter; a load overrides the step counted at pulse entry.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pos <= '0;
      end else if (bus.pos_load) begin
         r_pos <= bus.pos_load_val;
      end else if (w_enter_pulse) begin
         r_pos <= r_dir ? r_pos + POS_W'(1) : r_pos - POS_W'(1);
      end
   end

   assign bus.int_ready = w_int_win;
   assign bus.ext_ready = w_ext_win;
   assign bus.step_out  = (r_state == S_PULSE);
   assign bus.dir_out   = r_dir;
   assign bus.busy      = (r_state != S_IDLE);
   assign bus.grant_src = r_gsrc;
   assign bus.position  = r_pos;
endmodule

// File: tb/tb_step_source_arbiter.sv
// Bench for step_source_arbiter: timeline model of each granted step,
// directed scenarios with literal expectations, then random traffic.
module tb_step_source_arbiter;
   localparam int PW = 8;
   localparam int DS = 4;
   localparam int DH = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   step_source_arbiter_if #(.POS_W(32)) bus();

   step_source_arbiter #(
      .PULSE_W  (PW),
      .DIR_SETUP(DS),
      .DIR_HOLD (DH),
      .POS_W    (32)
   ) u_dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   int     vectors = 0;
   int     miscompares = 0;
   longint cyc = 0;
   logic   chk_en = 1'b0;

   longint      m_idle_at = 0;
   longint      m_rise = -1000;
   logic        m_dir = 1'b0;
   logic        m_last = 1'b1;
   logic        m_gsrc = 1'b0;
   logic [31:0] m_pos = 32'd0;

   longint gq[$];
   logic   gs[$];
   logic   t_int = 1'b0;
   logic   t_ext = 1'b0;
   logic   int_rearm = 1'b0;
   logic   ext_rearm = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [63:0] act,
                        input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s cyc=%0d got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   // Model: a grant at T fixes the step's rise, fall and idle cycles.
   always @(negedge clk) begin
      longint c;
      logic idle, open, ri, re, e_ir, e_er, e_step, src, rdir;
      c      = cyc;
      idle   = (c >= m_idle_at);
      open   = idle && !bus.halt;
      ri     = bus.src_sel[0] && bus.int_valid;
      re     = bus.src_sel[1] && bus.ext_valid;
      e_ir   = open && ri && (!re || m_last);
      e_er   = open && re && (!ri || !m_last);
      e_step = (c >= m_rise) && (c < m_rise + PW);
      if (chk_en) begin
         check("int_ready", bus.int_ready, e_ir);
         check("ext_ready", bus.ext_ready, e_er);
         check("step_out", bus.step_out, e_step);
         check("dir_out", bus.dir_out, m_dir);
         check("busy", bus.busy, !idle);
         check("grant_src", bus.grant_src, m_gsrc);
         check("position", bus.position, m_pos);
      end
      t_int = e_ir;
      t_ext = e_er;
      if (reset) begin
         m_idle_at = c + 1;
         m_rise    = -1000;
         m_dir     = 1'b0;
         m_last    = 1'b1;
         m_gsrc    = 1'b0;
         m_pos     = 32'd0;
      end else begin
         if (e_ir || e_er) begin
            src       = e_er;
            rdir      = src ? bus.ext_dir : bus.int_dir;
            m_rise    = c + 1 + ((rdir != m_dir) ? DS : 0);
            m_dir     = rdir;
            m_idle_at = m_rise + PW + DH;
            m_last    = src;
            m_gsrc    = src;
            gq.push_back(c);
            gs.push_back(src);
         end
         if (bus.pos_load)
            m_pos = bus.pos_load_val;
         else if (c + 1 == m_rise)
            m_pos = m_dir ? m_pos + 32'd1 : m_pos - 32'd1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (t_int && !int_rearm) bus.int_valid = 1'b0;
      if (t_ext && !ext_rearm) bus.ext_valid = 1'b0;
   endtask

   task automatic wait_grants(input int n, input string nm);
      for (int k = 0; k < 400 && gq.size() < n; k++) tick();
      check(nm, (gq.size() >= n), 1);
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 100 && bus.busy; k++) tick();
   endtask

   initial begin
      int     n0;
      longint c0;
      bus.src_sel      = 2'b00;
      bus.halt         = 1'b0;
      bus.int_valid    = 1'b0;
      bus.int_dir      = 1'b0;
      bus.ext_valid    = 1'b0;
      bus.ext_dir      = 1'b0;
      bus.pos_load     = 1'b0;
      bus.pos_load_val = 32'd0;
      reset = 1'b1;
      repeat (3) tick();
      reset  = 1'b0;
      chk_en = 1'b1;
      check("rst_step", bus.step_out, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_pos", bus.position, 0);
      check("rst_dir", bus.dir_out, 0);

      // Internal only, forward, held valid.
      bus.src_sel = 2'b01;
      bus.int_dir = 1'b1;
      bus.int_valid = 1'b1;
      int_rearm = 1'b1;
      wait_grants(3, "p1_grants");
      check("p1_first_gap", gq[1] - gq[0], 17);
      check("p1_period", gq[2] - gq[1], 13);
      check("p1_srcs", {gs[0], gs[1], gs[2]}, 0);
      check("p1_pos3", bus.position, 3);
      check("p1_step_hi", bus.step_out, 1);

      // Direction reversal.
      bus.int_dir = 1'b0;
      wait_grants(4, "p2_grant");
      check("p2_period", gq[3] - gq[2], 13);
      check("p2_dir_fell", bus.dir_out, 0);
      bus.int_valid = 1'b0;
      int_rearm = 1'b0;
      repeat (3) tick();
      check("p2_pre_rise", bus.step_out, 0);
      tick();
      check("p2_rise", bus.step_out, 1);
      check("p2_pos2", bus.position, 2);

      // Round-robin from a fresh pointer.
      wait_idle();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n0 = gq.size();
      bus.src_sel = 2'b11;
      bus.int_dir = 1'b0;
      bus.ext_dir = 1'b0;
      bus.int_valid = 1'b1;
      bus.ext_valid = 1'b1;
      int_rearm = 1'b1;
      ext_rearm = 1'b1;
      wait_grants(n0 + 3, "p3_grants");
      check("p3_srcs", {gs[n0], gs[n0+1], gs[n0+2]}, 3'b010);
      check("p3_period", gq[n0+2] - gq[n0+1], 13);
      check("p3_gsrc", bus.grant_src, 0);
      int_rearm = 1'b0;
      ext_rearm = 1'b0;
      bus.int_valid = 1'b0;
      bus.ext_valid = 1'b0;

      // Halt during a pulse.
      wait_idle();
      bus.src_sel = 2'b01;
      bus.int_dir = 1'b0;
      bus.int_valid = 1'b1;
      n0 = gq.size();
      wait_grants(n0 + 1, "p4_grant");
      check("p4_step_t1", bus.step_out, 1);
      bus.halt = 1'b1;
      bus.int_valid = 1'b1;
      repeat (7) tick();
      check("p4_step_t8", bus.step_out, 1);
      tick();
      check("p4_step_t9", bus.step_out, 0);
      repeat (12) tick();
      check("p4_halt_blocks", gq.size(), n0 + 1);
      c0 = cyc;
      bus.halt = 1'b0;
      tick();
      check("p4_release", gq.size(), n0 + 2);
      check("p4_release_cyc", gq[gq.size()-1], c0);

      // Position load and wrap.
      wait_idle();
      bus.pos_load = 1'b1;
      bus.pos_load_val = 32'h7FFF_FFFF;
      tick();
      bus.pos_load = 1'b0;
      check("p5_loaded", bus.position, 32'h7FFF_FFFF);
      bus.int_dir = 1'b1;
      bus.int_valid = 1'b1;
      n0 = gq.size();
      wait_grants(n0 + 1, "p5_grant");
      repeat (4) tick();
      check("p5_wrap_step", bus.step_out, 1);
      check("p5_wrap", bus.position, 32'h8000_0000);
      wait_idle();
      bus.int_dir = 1'b0;
      bus.int_valid = 1'b1;
      n0 = gq.size();
      wait_grants(n0 + 1, "p5_grant2");
      repeat (3) tick();
      bus.pos_load = 1'b1;
      bus.pos_load_val = 32'h1234_5678;
      tick();
      bus.pos_load = 1'b0;
      check("p5_load_wins_step", bus.step_out, 1);
      check("p5_load_wins", bus.position, 32'h1234_5678);

      // Reset three cycles into a pulse.
      wait_idle();
      bus.int_dir = 1'b0;
      bus.int_valid = 1'b1;
      n0 = gq.size();
      wait_grants(n0 + 1, "p6_grant");
      repeat (2) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("p6_step", bus.step_out, 0);
      check("p6_busy", bus.busy, 0);
      check("p6_pos", bus.position, 0);
      bus.int_dir = 1'b1;
      bus.int_valid = 1'b1;
      n0 = gq.size();
      wait_grants(n0 + 1, "p6_fresh");
      check("p6_dir", bus.dir_out, 1);
      repeat (4) tick();
      check("p6_rise", bus.step_out, 1);
      check("p6_pos1", bus.position, 1);

      // Random traffic.
      wait_idle();
      bus.src_sel = 2'b11;
      for (int i = 0; i < 3000; i++) begin
         tick();
         if ($urandom_range(49) == 0) bus.src_sel = 2'($urandom_range(3));
         if ($urandom_range(29) == 0) bus.halt = ~bus.halt;
         bus.pos_load = ($urandom_range(99) == 0);
         bus.pos_load_val = $urandom;
         reset = ($urandom_range(599) == 0);
         if (!bus.int_valid && $urandom_range(2) == 0) begin
            bus.int_valid = 1'b1;
            if ($urandom_range(3) == 0) bus.int_dir = ~bus.int_dir;
         end
         if (!bus.ext_valid && $urandom_range(2) == 0) begin
            bus.ext_valid = 1'b1;
            if ($urandom_range(3) == 0) bus.ext_dir = ~bus.ext_dir;
         end
      end
      reset = 1'b0;
      bus.pos_load = 1'b0;
      tick();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end
endmodule
